// File: rtl/j1_mem_responder_if.sv
// Bundles the j1 memory ports and the loader byte stream between the core/host side
// (master) and the memory responder (slave).
interface j1_mem_responder_if #(
  parameter int unsigned MEMWIDTH = 14
);
  logic [MEMWIDTH-1:0] code_addr;
  logic [15:0]         insn;
  logic [MEMWIDTH-1:0] mem_addr;
  logic                mem_wr;
  logic [15:0]         dout;
  logic [15:0]         din;
  logic [7:0]          ld_data;
  logic                ld_valid;
  logic                ld_ready;
  logic                cpu_reset;
  logic                ld_busy;
  logic                ld_error;

  modport master (
    output code_addr, mem_addr, mem_wr, dout, ld_data, ld_valid,
    input  insn, din, ld_ready, cpu_reset, ld_busy, ld_error
  );

  modport slave (
    input  code_addr, mem_addr, mem_wr, dout, ld_data, ld_valid,
    output insn, din, ld_ready, cpu_reset, ld_busy, ld_error
  );
endinterface

// File: rtl/j1_mem_responder.sv
// Dual-port word RAM for the j1 core with a checksummed byte-stream boot loader that
// holds the core in reset until a good image has been written.
module j1_mem_responder #(
  parameter int unsigned MEMWIDTH      = 14,
  parameter bit          LOAD_ON_RESET = 1'b1,
  parameter string       INIT_FILE     = ""
) (
  input logic              clk,
  input logic              reset,
  j1_mem_responder_if.slave bus
);
  localparam int unsigned Depth = 2 ** MEMWIDTH;

  typedef enum logic [2:0] {
    StLenLo, StLenHi, StDatLo, StDatHi, StSumLo, StSumHi, StErr, StRun
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [7:0]    lo_q, lo_d;
  logic [16:0]   cnt_q, cnt_d;
  logic [15:0]   sum_q, sum_d;
  logic          err_q, err_d;
  logic          cpu_reset_q, cpu_reset_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic [15:0]   insn_q, insn_d;
  logic [15:0]   din_q, din_d;

  logic [15:0]   mem [Depth];

  logic                accept;
  logic [15:0]         ld_word;
  logic [16:0]         cnt_inc;
  logic                we;
  logic [MEMWIDTH-1:0] waddr;
  logic [15:0]         wdata;

  assign accept  = bus.ld_valid & ready_q;
  assign ld_word = {bus.ld_data, lo_q};
  assign cnt_inc = cnt_q + 17'd1;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    err_d   = err_q;
    if (accept) begin
      unique case (state_q)
        StLenLo: begin
          lo_d    = bus.ld_data;
          state_d = StLenHi;
        end
        StLenHi: begin
          len_d = ld_word;
          cnt_d = '0;
          sum_d = '0;
          if ({1'b0, ld_word} > 17'(Depth)) begin
            state_d = StErr;
            err_d   = 1'b1;
          end else if (ld_word == 16'd0) begin
            state_d = StSumLo;
          end else begin
            state_d = StDatLo;
          end
        end
        StDatLo: begin
          lo_d    = bus.ld_data;
          state_d = StDatHi;
        end
        StDatHi: begin
          sum_d   = sum_q + ld_word;
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == {1'b0, len_q}) ? StSumLo : StDatLo;
        end
        StSumLo: begin
          lo_d    = bus.ld_data;
          state_d = StSumHi;
        end
        StSumHi: begin
          if (ld_word == sum_q) begin
            state_d = StRun;
            err_d   = 1'b0;
          end else begin
            state_d = StErr;
            err_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end
    // ERR lasts a single cycle and does not wait for a byte.
    if (state_q == StErr) state_d = StLenLo;

    cpu_reset_d = (state_d != StRun);
    busy_d      = (state_d != StRun);
    ready_d     = (state_d != StErr) && (state_d != StRun);
  end

  // Port B write source: the CPU owns it only in RUN, the loader otherwise.
  always_comb begin
    if (state_q == StRun) begin
      we    = bus.mem_wr;
      waddr = bus.mem_addr;
      wdata = bus.dout;
    end else begin
      we    = accept && (state_q == StDatHi);
      waddr = cnt_q[MEMWIDTH-1:0];
      wdata = ld_word;
    end
    insn_d = mem[bus.code_addr];
    din_d  = mem[bus.mem_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if (LOAD_ON_RESET) state_q <= StLenLo;
      else               state_q <= StRun;
      len_q       <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      err_q       <= 1'b0;
      cpu_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
      insn_q      <= '0;
      din_q       <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      err_q       <= err_d;
      cpu_reset_q <= cpu_reset_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      insn_q      <= insn_d;
      din_q       <= din_d;
    end
  end

  // Non-blocking write alongside the registered reads gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign bus.insn      = insn_q;
  assign bus.din       = din_q;
  assign bus.ld_ready  = ready_q;
  assign bus.cpu_reset = cpu_reset_q;
  assign bus.ld_busy   = busy_q;
  assign bus.ld_error  = err_q;
endmodule

// File: tb/tb_j1_mem_responder.sv
// Bench for j1_mem_responder: table of load streams, hand-written corner sequences and
// randomized loads checked against a stream-level model of the RAM image.
module tb_j1_mem_responder;
  localparam int unsigned MW    = 4;
  localparam int unsigned Depth = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  j1_mem_responder_if #(.MEMWIDTH(MW)) bus ();
  j1_mem_responder_if #(.MEMWIDTH(MW)) bus0 ();

  j1_mem_responder #(.MEMWIDTH(MW), .LOAD_ON_RESET(1'b1), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  j1_mem_responder #(.MEMWIDTH(MW), .LOAD_ON_RESET(1'b0), .INIT_FILE("")) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] model_mem [Depth];
  bit          model_ok  [Depth];

  typedef struct {
    bit          do_reset;
    int          n;
    logic [95:0] bytes;
    bit          exp_cpu_reset;
    bit          exp_err;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic do_reset(input bit chk);
    @(negedge clk);
    reset        = 1'b1;
    bus.ld_valid = 1'b0;
    bus.mem_wr   = 1'b0;
    repeat (2) @(negedge clk);
    if (chk) begin
      check("rst_insn", bus.insn, 16'h0);
      check("rst_din", bus.din, 16'h0);
      check("rst_cpu_reset", bus.cpu_reset, 1'b1);
      check("rst_ld_ready", bus.ld_ready, 1'b0);
      check("rst_ld_busy", bus.ld_busy, 1'b1);
      check("rst_ld_error", bus.ld_error, 1'b0);
      check("rst0_cpu_reset", bus0.cpu_reset, 1'b1);
    end
    reset = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.ld_data  = b;
    bus.ld_valid = 1'b1;
    while (!bus.ld_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ld_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.ld_valid = 1'b0;
  endtask

  task automatic send_stream(input logic [7:0] s[$], input int gap_max);
    foreach (s[i]) begin
      send_byte(s[i]);
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
    end
  endtask

  // Stream-level model: every completed data word lands in RAM, checksum decides release.
  task automatic model_apply(input logic [7:0] s[$], output bit run);
    int          len;
    logic [15:0] sum, w, got;
    run = 1'b0;
    sum = '0;
    len = 32'({s[1], s[0]});
    if (len > Depth) return;
    for (int i = 0; i < len; i++) begin
      w = {s[3 + 2 * i], s[2 + 2 * i]};
      model_mem[i] = w;
      model_ok[i]  = 1'b1;
      sum += w;
    end
    got = {s[2 * len + 3], s[2 * len + 2]};
    run = (got == sum);
  endtask

  task automatic build_stream(input int len, input bit corrupt, output logic [7:0] s[$]);
    logic [15:0] sum;
    logic [15:0] w;
    sum = '0;
    s   = {};
    s.push_back(len[7:0]);
    s.push_back(len[15:8]);
    if (len > Depth) return;
    for (int i = 0; i < len; i++) begin
      w = 16'($urandom);
      s.push_back(w[7:0]);
      s.push_back(w[15:8]);
      sum += w;
    end
    if (corrupt) sum ^= 16'(1 << $urandom_range(0, 15));
    s.push_back(sum[7:0]);
    s.push_back(sum[15:8]);
  endtask

  task automatic check_ram(input string tag);
    for (int a = 0; a < Depth; a++) begin
      if (model_ok[a]) begin
        bus.code_addr = 4'(a);
        bus.mem_addr  = 4'(a);
        @(negedge clk);
        check({tag, "_insn"}, bus.insn, model_mem[a]);
        check({tag, "_din"}, bus.din, model_mem[a]);
      end
    end
  endtask

  initial begin
    logic [7:0] s[$];
    bit         run;

    bus.code_addr = '0;
    bus.mem_addr  = '0;
    bus.mem_wr    = 1'b0;
    bus.dout      = '0;
    bus.ld_data   = '0;
    bus.ld_valid  = 1'b0;
    bus0.code_addr = '0;
    bus0.mem_addr  = '0;
    bus0.mem_wr    = 1'b0;
    bus0.dout      = '0;
    bus0.ld_data   = 8'h55;
    bus0.ld_valid  = 1'b1;
    for (int a = 0; a < Depth; a++) model_ok[a] = 1'b0;

    vecs[0] = '{1'b1, 8, 96'h0200_3412_7856_AC68_0000_0000, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8, 96'h0200_3412_7856_AC69_0000_0000, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 8, 96'h0200_3412_7856_AC68_0000_0000, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 2, 96'h1100_0000_0000_0000_0000_0000, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 4, 96'h0000_0000_0000_0000_0000_0000, 1'b0, 1'b0};

    // Reset values, then the LOAD_ON_RESET=0 instance releases one cycle later.
    do_reset(1'b1);
    @(negedge clk);
    check("r0_cpu_reset", bus0.cpu_reset, 1'b0);
    check("r0_ld_ready", bus0.ld_ready, 1'b0);
    check("r0_ld_busy", bus0.ld_busy, 1'b0);
    check("r1_ld_ready", bus.ld_ready, 1'b1);

    // Release timing on the basic good stream.
    s = {8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hAC};
    send_stream(s, 0);
    bus.ld_data  = 8'h68;
    bus.ld_valid = 1'b1;
    check("pre_release_cpu_reset", bus.cpu_reset, 1'b1);
    @(negedge clk);
    bus.ld_valid = 1'b0;
    check("release_cpu_reset", bus.cpu_reset, 1'b0);
    check("release_ld_error", bus.ld_error, 1'b0);
    check("release_ld_busy", bus.ld_busy, 1'b0);
    bus.code_addr = 4'd1;
    @(negedge clk);
    check("insn_addr1", bus.insn, 16'h5678);
    model_mem[0] = 16'h1234; model_ok[0] = 1'b1;
    model_mem[1] = 16'h5678; model_ok[1] = 1'b1;

    // Table-driven load streams.
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].do_reset) do_reset(1'b0);
      s = {};
      for (int i = 0; i < vecs[v].n; i++) s.push_back(vecs[v].bytes[95 - 8 * i -: 8]);
      send_stream(s, 0);
      model_apply(s, run);
      repeat (3) @(negedge clk);
      check($sformatf("vec%0d_cpu_reset", v), bus.cpu_reset, vecs[v].exp_cpu_reset);
      check($sformatf("vec%0d_ld_error", v), bus.ld_error, vecs[v].exp_err);
      check($sformatf("vec%0d_ld_busy", v), bus.ld_busy, vecs[v].exp_cpu_reset);
      check($sformatf("vec%0d_ld_ready", v), bus.ld_ready, vecs[v].exp_cpu_reset);
      check_ram($sformatf("vec%0d_ram", v));
    end

    // Reset mid-load: written words persist, the next good load releases the core.
    do_reset(1'b0);
    s = {8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_stream(s, 1);
    model_mem[0] = 16'h2211;
    model_mem[1] = 16'h4433;
    do_reset(1'b0);
    s = {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hEF, 8'hBE};
    send_stream(s, 0);
    model_apply(s, run);
    repeat (2) @(negedge clk);
    check("midrst_cpu_reset", bus.cpu_reset, 1'b0);
    check("midrst_ld_error", bus.ld_error, 1'b0);
    check_ram("midrst_ram");

    // RUN-state data port, read-first on both ports.
    bus.mem_addr = 4'd5;
    bus.dout     = 16'h1111;
    bus.mem_wr   = 1'b1;
    @(negedge clk);
    bus.dout = 16'hBEEF;
    @(negedge clk);
    bus.mem_wr = 1'b0;
    check("rdw_old_din", bus.din, 16'h1111);
    @(negedge clk);
    check("rdw_new_din", bus.din, 16'hBEEF);
    bus.code_addr = 4'd5;
    @(negedge clk);
    check("rdw_code_insn", bus.insn, 16'hBEEF);
    model_mem[5] = 16'hBEEF; model_ok[5] = 1'b1;

    // Loader isolation: CPU writes ignored during the load, gaps change nothing.
    do_reset(1'b0);
    bus.mem_wr   = 1'b1;
    bus.mem_addr = 4'd0;
    bus.dout     = 16'hFFFF;
    s = {8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hAC};
    send_stream(s, 3);
    bus.mem_wr = 1'b0;
    send_byte(8'h68);
    s.push_back(8'h68);
    model_apply(s, run);
    @(negedge clk);
    check("iso_cpu_reset", bus.cpu_reset, 1'b0);
    check_ram("iso_ram");

    // Randomized loads with gaps, CPU-port noise, bad sums and oversize lengths.
    for (int it = 0; it < 30; it++) begin
      int len;
      bit corrupt;
      do_reset(1'b0);
      if (it == 0)          len = 16;
      else if (it == 1)     len = 17;
      else if (it % 7 == 3) len = $urandom_range(17, 65535);
      else                  len = $urandom_range(0, 16);
      corrupt = ($urandom_range(0, 3) == 0);
      build_stream(len, corrupt, s);
      foreach (s[i]) begin
        if (i < s.size() - 1) begin
          bus.mem_wr   = 1'($urandom);
          bus.mem_addr = 4'($urandom);
          bus.dout     = 16'($urandom);
        end else begin
          bus.mem_wr = 1'b0;
        end
        send_byte(s[i]);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      bus.mem_wr = 1'b0;
      model_apply(s, run);
      repeat (3) @(negedge clk);
      check($sformatf("rnd%0d_cpu_reset", it), bus.cpu_reset, !run);
      check($sformatf("rnd%0d_ld_error", it), bus.ld_error, !run);
      check_ram($sformatf("rnd%0d_ram", it));
    end

    check("r0_final_cpu_reset", bus0.cpu_reset, 1'b0);
    check("r0_final_ld_ready", bus0.ld_ready, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
